// File: rtl/addr_map_rule_pkg.sv
// Shared address-map rule type used by interconnect decoders.
package addr_map_rule_pkg;

    // One address window; end_addr is exclusive.
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

endpackage

// File: rtl/cei_mochila_pkg.sv
// Common types, widths and defaults for the cei_mochila OBI demultiplexer.
package cei_mochila_pkg;

    import addr_map_rule_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned OUT_W  = 8;
    // Wide enough for NSLAVE up to 16 plus the error target.
    localparam int unsigned TGT_W  = 5;

    typedef logic [TGT_W-1:0] tgt_t;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hBADA_CCE5;

    // Default memory map; first entry lands on index 3.
    localparam addr_map_rule_t [3:0] XBAR_ADDR_RULES = '{
        '{idx: 32'd3, start_addr: 32'hF000_0000, end_addr: 32'hF020_0000},
        '{idx: 32'd2, start_addr: 32'h0000_0100, end_addr: 32'h0001_0000},
        '{idx: 32'd1, start_addr: 32'h1000_0000, end_addr: 32'h1001_0000},
        '{idx: 32'd0, start_addr: 32'h0000_0000, end_addr: 32'h0000_0100}
    };

    // Unmapped accesses are routed to the internal target just past the last slave.
    function automatic tgt_t err_tgt(input int unsigned nslave);
        return tgt_t'(nslave);
    endfunction

    // Counter must hold the values 0..max_out inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/cei_mochila_obi_demux_if.sv
// OBI master-side port plus broadcast slave-side bus of the demultiplexer.
interface cei_mochila_obi_demux_if
    import cei_mochila_pkg::*;
#(
    parameter int unsigned NSLAVE = 4
);

    logic                           req_i;
    logic [ADDR_W-1:0]              addr_i;
    logic                           we_i;
    logic [BE_W-1:0]                be_i;
    logic [DATA_W-1:0]              wdata_i;
    logic                           gnt_o;
    logic                           rvalid_o;
    logic [DATA_W-1:0]              rdata_o;
    logic                           err_o;
    logic [NSLAVE-1:0]              slv_req_o;
    logic [ADDR_W-1:0]              slv_addr_o;
    logic                           slv_we_o;
    logic [BE_W-1:0]                slv_be_o;
    logic [DATA_W-1:0]              slv_wdata_o;
    logic [NSLAVE-1:0]              slv_gnt_i;
    logic [NSLAVE-1:0]              slv_rvalid_i;
    logic [NSLAVE-1:0][DATA_W-1:0]  slv_rdata_i;
    logic [OUT_W-1:0]               outstanding_o;
    logic                           proto_err_o;

    // View taken by the demultiplexer itself.
    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output slv_req_o, slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o,
        input  slv_gnt_i, slv_rvalid_i, slv_rdata_i,
        output outstanding_o, proto_err_o
    );

    // View taken by the environment (master and slaves).
    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  slv_req_o, slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o,
        output slv_gnt_i, slv_rvalid_i, slv_rdata_i,
        input  outstanding_o, proto_err_o
    );

endinterface

// File: rtl/cei_mochila_addr_decode.sv
// Combinational address decoder: lowest matching valid rule wins.
module cei_mochila_addr_decode
    import cei_mochila_pkg::*;
    import addr_map_rule_pkg::*;
#(
    parameter int unsigned                     NRULES     = 4,
    parameter int unsigned                     NSLAVE     = 4,
    parameter addr_map_rule_t [NRULES-1:0]     ADDR_RULES = XBAR_ADDR_RULES
) (
    input  logic [ADDR_W-1:0] addr_i,
    output tgt_t              tgt_c
);

    // Walk from the highest rule down so the lowest index overrides; bad idx is skipped.
    always_comb begin
        tgt_c = err_tgt(NSLAVE);
        for (int i = int'(NRULES) - 1; i >= 0; i--) begin
            if ((addr_i >= ADDR_RULES[i].start_addr) &&
                (addr_i <  ADDR_RULES[i].end_addr)   &&
                (ADDR_RULES[i].idx < 32'(NSLAVE))) begin
                tgt_c = tgt_t'(ADDR_RULES[i].idx);
            end
        end
    end

endmodule

// File: rtl/cei_mochila_obi_demux.sv
// OBI 1-to-N demultiplexer with in-order outstanding tracking and an error responder.
module cei_mochila_obi_demux
    import cei_mochila_pkg::*;
    import addr_map_rule_pkg::*;
#(
    parameter int unsigned                 NSLAVE          = 4,
    parameter int unsigned                 NRULES          = 4,
    parameter addr_map_rule_t [NRULES-1:0] ADDR_RULES      = XBAR_ADDR_RULES,
    parameter int unsigned                 MAX_OUTSTANDING = 4,
    parameter logic [DATA_W-1:0]           ERR_RDATA       = ERR_RDATA_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    cei_mochila_obi_demux_if.slave   bus
);

    localparam int unsigned      CNT_W   = cnt_width(MAX_OUTSTANDING);
    localparam tgt_t             ERR_TGT = err_tgt(NSLAVE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]   cnt;
    tgt_t               last_tgt;
    logic               err_pend;
    logic               proto_err;

    tgt_t               tgt_c;
    logic               stall_c;
    logic               gnt_c;
    logic               accept_c;
    logic               rsp_c;
    logic               sel_rvalid_c;
    logic [DATA_W-1:0]  sel_rdata_c;
    logic               spurious_c;
    logic [NSLAVE-1:0]  slv_req_c;
    logic [DATA_W-1:0]  rdata_c;
    logic               err_c;

    cei_mochila_addr_decode #(
        .NRULES     (NRULES),
        .NSLAVE     (NSLAVE),
        .ADDR_RULES (ADDR_RULES)
    ) u_decode (
        .addr_i (bus.addr_i),
        .tgt_c  (tgt_c)
    );

    // Pick the response channel of the slave that owns the outstanding transactions.
    always_comb begin
        sel_rvalid_c = 1'b0;
        sel_rdata_c  = '0;
        for (int unsigned k = 0; k < NSLAVE; k++) begin
            if (last_tgt == tgt_t'(k)) begin
                sel_rvalid_c = bus.slv_rvalid_i[k];
                sel_rdata_c  = bus.slv_rdata_i[k];
            end
        end
    end

    // Any slave response with nothing outstanding for that slave is a protocol error.
    always_comb begin
        spurious_c = 1'b0;
        for (int unsigned j = 0; j < NSLAVE; j++) begin
            if (bus.slv_rvalid_i[j] && ((cnt == '0) || (last_tgt != tgt_t'(j)))) begin
                spurious_c = 1'b1;
            end
        end
    end

    // Response for the oldest outstanding transaction; the error responder answers a cycle after accept.
    always_comb begin
        rsp_c   = 1'b0;
        rdata_c = '0;
        err_c   = 1'b0;
        if (cnt != '0) begin
            if (last_tgt == ERR_TGT) begin
                rsp_c   = err_pend;
                err_c   = err_pend;
                rdata_c = err_pend ? ERR_RDATA : '0;
            end else begin
                rsp_c   = sel_rvalid_c;
                rdata_c = sel_rdata_c;
            end
        end
    end

    // Hold off a full counter (unless a response frees a slot now) or a switch of target with traffic in flight.
    always_comb begin
        stall_c = bus.req_i &&
                  (((cnt == CNT_MAX) && !rsp_c) ||
                   ((cnt != '0) && (tgt_c != last_tgt)));
    end

    // Route the request and return the grant with zero latency.
    always_comb begin
        gnt_c     = 1'b0;
        slv_req_c = '0;
        if (!rst_i && !stall_c) begin
            if (tgt_c == ERR_TGT) begin
                gnt_c = bus.req_i;
            end else begin
                for (int unsigned k = 0; k < NSLAVE; k++) begin
                    if (tgt_c == tgt_t'(k)) begin
                        slv_req_c[k] = bus.req_i;
                        gnt_c        = bus.slv_gnt_i[k];
                    end
                end
            end
        end
        accept_c = bus.req_i && gnt_c;
    end

    // Outstanding counter, owner tracking, error responder and sticky protocol flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            last_tgt  <= '0;
            err_pend  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (accept_c) begin
                last_tgt <= tgt_c;
            end
            err_pend <= accept_c && (tgt_c == ERR_TGT);
            case ({accept_c, rsp_c})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (spurious_c) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign bus.gnt_o         = gnt_c;
    assign bus.rvalid_o      = rsp_c;
    assign bus.rdata_o       = rdata_c;
    assign bus.err_o         = err_c;
    assign bus.slv_req_o     = slv_req_c;
    assign bus.slv_addr_o    = bus.addr_i;
    assign bus.slv_we_o      = bus.we_i;
    assign bus.slv_be_o      = bus.be_i;
    assign bus.slv_wdata_o   = bus.wdata_i;
    assign bus.outstanding_o = OUT_W'(cnt);
    assign bus.proto_err_o   = proto_err;

endmodule

// File: tb/tb_cei_mochila_obi_demux.sv
// Directed bench for the OBI demultiplexer using the default memory map.
module tb_cei_mochila_obi_demux;

    import cei_mochila_pkg::*;

    logic clk_i;
    logic rst_i;
    int   vectors;
    int   miscompares;

    cei_mochila_obi_demux_if #(.NSLAVE(4)) bus ();

    cei_mochila_obi_demux #(
        .NSLAVE          (4),
        .NRULES          (4),
        .ADDR_RULES      (XBAR_ADDR_RULES),
        .MAX_OUTSTANDING (4),
        .ERR_RDATA       (32'hBADA_CCE5)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.req_i        = 1'b0;
        bus.addr_i       = '0;
        bus.we_i         = 1'b0;
        bus.be_i         = '0;
        bus.wdata_i      = '0;
        bus.slv_gnt_i    = '0;
        bus.slv_rvalid_i = '0;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        bus.slv_rdata_i = '0;
        rst_i = 1'b1;

        // Reset: request with a granting slave must still see nothing.
        bus.req_i     = 1'b1;
        bus.addr_i    = 32'h1000_0000;
        bus.slv_gnt_i = 4'b1111;
        mid();
        chk("rst_gnt",       32'(bus.gnt_o), 32'd0);
        chk("rst_slv_req",   32'(bus.slv_req_o), 32'd0);
        chk("rst_outst",     32'(bus.outstanding_o), 32'd0);
        chk("rst_rvalid",    32'(bus.rvalid_o), 32'd0);
        chk("rst_proto",     32'(bus.proto_err_o), 32'd0);
        tick();
        idle();
        rst_i = 1'b0;
        tick();

        // Read to slave 3, granted at once, data one cycle later.
        bus.req_i        = 1'b1;
        bus.addr_i       = 32'hF010_0010;
        bus.slv_gnt_i[3] = 1'b1;
        mid();
        chk("rd3_gnt",       32'(bus.gnt_o), 32'd1);
        chk("rd3_slv_req",   32'(bus.slv_req_o), 32'h8);
        chk("rd3_slv_addr",  bus.slv_addr_o, 32'hF010_0010);
        chk("rd3_rvalid0",   32'(bus.rvalid_o), 32'd0);
        tick();
        idle();
        bus.slv_rvalid_i[3] = 1'b1;
        bus.slv_rdata_i[3]  = 32'h1234_5678;
        mid();
        chk("rd3_rvalid",    32'(bus.rvalid_o), 32'd1);
        chk("rd3_rdata",     bus.rdata_o, 32'h1234_5678);
        chk("rd3_err",       32'(bus.err_o), 32'd0);
        chk("rd3_outst",     32'(bus.outstanding_o), 32'd1);
        tick();
        idle();
        mid();
        chk("rd3_done_outst", 32'(bus.outstanding_o), 32'd0);
        chk("rd3_done_rdata", bus.rdata_o, 32'd0);
        tick();

        // Unmapped read gets an immediate grant and an error response.
        bus.req_i     = 1'b1;
        bus.addr_i    = 32'hBADA_CCE4;
        bus.slv_gnt_i = 4'b1111;
        mid();
        chk("err_gnt",       32'(bus.gnt_o), 32'd1);
        chk("err_slv_req",   32'(bus.slv_req_o), 32'd0);
        tick();
        // Second unmapped access back-to-back with the first response.
        mid();
        chk("err_rvalid",    32'(bus.rvalid_o), 32'd1);
        chk("err_rdata",     bus.rdata_o, 32'hBADA_CCE5);
        chk("err_err",       32'(bus.err_o), 32'd1);
        chk("err_b2b_gnt",   32'(bus.gnt_o), 32'd1);
        tick();
        idle();
        mid();
        chk("err_b2b_rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("err_b2b_err",    32'(bus.err_o), 32'd1);
        chk("err_b2b_outst",  32'(bus.outstanding_o), 32'd1);
        tick();
        mid();
        chk("err_end_rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("err_end_outst",  32'(bus.outstanding_o), 32'd0);
        tick();

        // Five back-to-back requests to slave 1 with responses withheld.
        bus.req_i        = 1'b1;
        bus.addr_i       = 32'h1000_0040;
        bus.slv_gnt_i[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            mid();
            chk($sformatf("full_gnt%0d", n),   32'(bus.gnt_o), 32'd1);
            chk($sformatf("full_outst%0d", n), 32'(bus.outstanding_o), 32'(n));
            tick();
        end
        mid();
        chk("full_stall_gnt",  32'(bus.gnt_o), 32'd0);
        chk("full_stall_req",  32'(bus.slv_req_o), 32'd0);
        chk("full_outst4",     32'(bus.outstanding_o), 32'd4);
        tick();
        bus.slv_rvalid_i[1] = 1'b1;
        bus.slv_rdata_i[1]  = 32'h0000_00A1;
        mid();
        chk("full_rsp_gnt",    32'(bus.gnt_o), 32'd1);
        chk("full_rsp_rvalid", 32'(bus.rvalid_o), 32'd1);
        chk("full_rsp_rdata",  bus.rdata_o, 32'h0000_00A1);
        tick();
        idle();
        mid();
        chk("full_hold_outst", 32'(bus.outstanding_o), 32'd4);
        tick();
        bus.slv_rvalid_i[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            mid();
            chk($sformatf("drain_rvalid%0d", n), 32'(bus.rvalid_o), 32'd1);
            tick();
        end
        idle();
        mid();
        chk("drain_outst",     32'(bus.outstanding_o), 32'd0);
        chk("drain_proto",     32'(bus.proto_err_o), 32'd0);
        tick();

        // Target switch waits for the older slave's response.
        bus.req_i        = 1'b1;
        bus.addr_i       = 32'h1000_0000;
        bus.slv_gnt_i[1] = 1'b1;
        mid();
        chk("sw_first_gnt",    32'(bus.gnt_o), 32'd1);
        tick();
        idle();
        bus.req_i        = 1'b1;
        bus.addr_i       = 32'h0000_0100;
        bus.slv_gnt_i[2] = 1'b1;
        mid();
        chk("sw_stall_gnt",    32'(bus.gnt_o), 32'd0);
        chk("sw_stall_req",    32'(bus.slv_req_o), 32'd0);
        tick();
        bus.slv_rvalid_i[1] = 1'b1;
        bus.slv_rdata_i[1]  = 32'h0000_00B1;
        mid();
        chk("sw_rsp_gnt",      32'(bus.gnt_o), 32'd0);
        chk("sw_rsp_rvalid",   32'(bus.rvalid_o), 32'd1);
        tick();
        bus.slv_rvalid_i = '0;
        mid();
        chk("sw_go_gnt",       32'(bus.gnt_o), 32'd1);
        chk("sw_go_req",       32'(bus.slv_req_o), 32'h4);
        tick();
        idle();
        mid();
        chk("sw_outst1",       32'(bus.outstanding_o), 32'd1);
        tick();
        bus.slv_rvalid_i[2] = 1'b1;
        bus.slv_rdata_i[2]  = 32'h0000_00C2;
        mid();
        chk("sw_rdata2",       bus.rdata_o, 32'h0000_00C2);
        tick();
        idle();
        mid();
        chk("sw_end_outst",    32'(bus.outstanding_o), 32'd0);
        chk("sw_end_proto",    32'(bus.proto_err_o), 32'd0);
        tick();

        // Spurious response with nothing outstanding.
        bus.slv_rvalid_i[2] = 1'b1;
        bus.slv_rdata_i[2]  = 32'h0000_0DD2;
        mid();
        chk("spur_rvalid",     32'(bus.rvalid_o), 32'd0);
        chk("spur_rdata",      bus.rdata_o, 32'd0);
        tick();
        idle();
        mid();
        chk("spur_proto",      32'(bus.proto_err_o), 32'd1);
        tick();
        tick();
        mid();
        chk("spur_sticky",     32'(bus.proto_err_o), 32'd1);
        tick();

        // Three outstanding to slave 1, then reset mid-transaction.
        bus.req_i        = 1'b1;
        bus.addr_i       = 32'h1000_0010;
        bus.slv_gnt_i[1] = 1'b1;
        tick();
        tick();
        tick();
        mid();
        chk("rst3_outst",      32'(bus.outstanding_o), 32'd3);
        tick();
        rst_i = 1'b1;
        mid();
        chk("rst3_now_outst",  32'(bus.outstanding_o), 32'd0);
        chk("rst3_now_gnt",    32'(bus.gnt_o), 32'd0);
        chk("rst3_now_proto",  32'(bus.proto_err_o), 32'd0);
        tick();
        idle();
        rst_i = 1'b0;
        // Late response from the discarded transaction.
        bus.slv_rvalid_i[1] = 1'b1;
        mid();
        chk("late_rvalid",     32'(bus.rvalid_o), 32'd0);
        tick();
        idle();
        mid();
        chk("late_proto",      32'(bus.proto_err_o), 32'd1);
        tick();

        // Normal write to slave 0 after reset.
        bus.req_i        = 1'b1;
        bus.addr_i       = 32'h0000_0010;
        bus.we_i         = 1'b1;
        bus.be_i         = 4'hF;
        bus.wdata_i      = 32'hDEAD_BEEF;
        bus.slv_gnt_i[0] = 1'b1;
        mid();
        chk("wr_gnt",          32'(bus.gnt_o), 32'd1);
        chk("wr_slv_req",      32'(bus.slv_req_o), 32'h1);
        chk("wr_slv_we",       32'(bus.slv_we_o), 32'd1);
        chk("wr_slv_wdata",    bus.slv_wdata_o, 32'hDEAD_BEEF);
        tick();
        idle();
        bus.slv_rvalid_i[0] = 1'b1;
        bus.slv_rdata_i[0]  = 32'h0000_0E00;
        mid();
        chk("wr_rvalid",       32'(bus.rvalid_o), 32'd1);
        chk("wr_rdata",        bus.rdata_o, 32'h0000_0E00);
        chk("wr_err",          32'(bus.err_o), 32'd0);
        tick();
        idle();
        mid();
        chk("wr_end_outst",    32'(bus.outstanding_o), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cei_mochila_obi_demux.md
CEI_MOCHILA_OBI_DEMUX -- requirements
Module: cei_mochila_obi_demux

Interface
REQ-001 Parameters SHALL be:
  - NSLAVE, default 4, number of downstream slave ports (1..16).
  - NRULES, default 4, number of address rules.
  - ADDR_RULES, default XBAR_ADDR_RULES, addr_map_rule_t array [NRULES-1:0], end_addr exclusive.
  - MAX_OUTSTANDING, default 4, maximum accepted-but-unanswered transactions (1..255).
  - ERR_RDATA, default 32'hBADACCE5, rdata returned for unmapped accesses.
REQ-002 Ports SHALL be:
  - clk_i  in  1  clock.
  - rst_i  in  1  asynchronous, active-high reset.
  - req_i  in  1  master request.
  - addr_i  in  32  address.
  - we_i  in  1  write enable.
  - be_i  in  4  byte enables.
  - wdata_i  in  32  write data.
  - gnt_o  out  1  grant to master.
  - rvalid_o  out  1  response valid.
  - rdata_o  out  32  response data.
  - err_o  out  1  response is an address error.
  - slv_req_o  out  NSLAVE  per-slave request.
  - slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o  out  32/1/4/32  broadcast to all slaves.
  - slv_gnt_i  in  NSLAVE  per-slave grant.
  - slv_rvalid_i  in  NSLAVE  per-slave response valid.
  - slv_rdata_i  in  NSLAVE x 32  per-slave response data.
  - outstanding_o  out  8  current outstanding count.
  - proto_err_o  out  1  sticky spurious-response flag.

Function
REQ-003 Decode SHALL be combinational: a rule matches when start_addr <= addr_i < end_addr; the lowest rule index wins; the target is that rule's idx; no match selects the internal error target, encoded as NSLAVE.
REQ-004 A rule idx >= NSLAVE SHALL be treated as no match.
REQ-005 The block SHALL hold a counter cnt (0..MAX_OUTSTANDING) and a register last_tgt.
REQ-006 The block SHALL stall, with no slv_req_o asserted and gnt_o=0, when req_i=1 and either cnt==MAX_OUTSTANDING, or cnt>0 and the decoded target != last_tgt.
REQ-007 When not stalled and the target is slave k, the block SHALL set slv_req_o[k]=req_i and gnt_o=slv_gnt_i[k], in the same cycle with zero latency.
REQ-008 When not stalled and the target is the error target, the block SHALL set gnt_o=req_i.
REQ-009 An accept is req_i && gnt_o; on an accept, last_tgt SHALL load the decoded target.
REQ-010 The error responder SHALL assert rvalid_o=1, err_o=1 and rdata_o=ERR_RDATA exactly one cycle after each error-target accept; back-to-back error accepts SHALL give back-to-back responses.
REQ-011 For slave targets, the block SHALL set rvalid_o=slv_rvalid_i[last_tgt], rdata_o=slv_rdata_i[last_tgt] and err_o=0 whenever cnt>0.
REQ-012 When cnt==0, the block SHALL drive rvalid_o=0, rdata_o=0 and err_o=0.
REQ-013 cnt SHALL update as follows:
  - +1 on an accept without a response.
  - -1 on a response without an accept.
  - unchanged on a simultaneous accept and response.
REQ-014 outstanding_o SHALL equal cnt, zero-extended.
REQ-015 A slv_rvalid_i[j] asserted while cnt==0 or j != last_tgt SHALL be dropped and SHALL set proto_err_o, which holds until reset.
REQ-016 Write accesses SHALL follow the same handshake and response rules as reads, with rdata_o = the slave's rdata (ERR_RDATA for unmapped).

Reset
REQ-017 While rst_i=1, the block SHALL set cnt=0, last_tgt=0, the error-responder pending flag=0 and proto_err_o=0.
REQ-018 While rst_i=1, gnt_o, rvalid_o and all slv_req_o SHALL be 0.
REQ-019 A reset mid-transaction SHALL discard all outstanding state; late slave responses after reset SHALL set proto_err_o.

Structure
REQ-020 The error-target encoding, ERR_RDATA default and MAX_OUTSTANDING width rule SHALL live in cei_mochila_pkg, reusing addr_map_rule_t from addr_map_rule_pkg.
REQ-021 The address decode SHALL be one sub-module, cei_mochila_addr_decode, which is combinational and parametrised by NRULES, NSLAVE and ADDR_RULES.

Verification
REQ-022 A read at 0xF0100010, with memory slave idx3 granting immediately and rvalid one cycle later with data 0x12345678, SHALL give gnt_o in cycle 0 and rvalid_o=1, rdata_o=0x12345678, err_o=0 in cycle 1.
REQ-023 A read at 0xBADACCE4 (unmapped) SHALL give gnt_o in the same cycle and, next cycle, rvalid_o=1, rdata_o=0xBADACCE5, err_o=1.
REQ-024 With MAX_OUTSTANDING=4, five back-to-back requests to idx1 with slave responses withheld SHALL give four grants, a stall on the fifth, and outstanding_o=4; one response SHALL cause the fifth to be granted in the same cycle as the response.
REQ-025 A request to idx2 at address 0x00000100 while one idx1 transaction is outstanding SHALL stall until the idx1 rvalid, then be granted the following cycle with cnt back to 1.
REQ-026 slv_rvalid_i[2] asserted while cnt==0 SHALL produce rvalid_o=0 and proto_err_o=1, sticky until rst_i.
REQ-027 Asserting rst_i while cnt==3 SHALL give outstanding_o=0 and gnt_o=0 immediately, with normal operation resuming after deassertion.
